// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller between the EX stage and the 34-cycle iterative divider.
// Build option: `define DIV_RESULT_CACHE_EN adds a one-entry result cache that bypasses the divider on a repeat.
module div_issue_ctrl #(
    parameter int TAG_W    = 5,
    parameter int WDOG_CYC = 48
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_go,
    output logic             div_signed,
    output logic [31:0]      div_x,
    output logic [31:0]      div_y,
    input  logic             div_complete,
    input  logic [31:0]      div_s,
    input  logic [31:0]      div_r,
    output logic             busy,
    output logic             div_err
);
    // state | meaning
    // IDLE  | no op in flight, ready to accept
    // BUSY  | divider running (div_go high), watchdog counting
    // CAPT  | sample quotient/remainder the cycle after complete
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, BUSY, CAPT, DONE} state_t;

    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    state_t            state;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              mod_sel;
    logic              accept;
    logic              cache_hit;
    logic [31:0]       hit_result;

    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign div_go    = (state == BUSY);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

`ifdef DIV_RESULT_CACHE_EN
    logic        c_valid;
    logic        c_signed;
    logic [31:0] c_x;
    logic [31:0] c_y;
    logic [31:0] c_q;
    logic [31:0] c_r;

    assign cache_hit  = c_valid && (c_x == in_src1) && (c_y == in_src2) && (c_signed == !in_op[1]);
    assign hit_result = in_op[0] ? c_r : c_q;

    // Only real completions reach CAPT, so watchdog results never pollute the entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_x      <= '0;
            c_y      <= '0;
            c_q      <= '0;
            c_r      <= '0;
        end else if (!flush && (state == CAPT)) begin
            c_valid  <= 1'b1;
            c_signed <= div_signed;
            c_x      <= div_x;
            c_y      <= div_y;
            c_q      <= div_s;
            c_r      <= div_r;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign hit_result = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wdog_cnt   <= '0;
            div_err    <= 1'b0;
            div_signed <= 1'b0;
            div_x      <= '0;
            div_y      <= '0;
            out_result <= '0;
            out_tag    <= '0;
            mod_sel    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            // Accept only happens from IDLE or a draining DONE, so div_go is low this cycle.
            div_x      <= in_src1;
            div_y      <= in_src2;
            div_signed <= !in_op[1];
            mod_sel    <= in_op[0];
            out_tag    <= in_tag;
            wdog_cnt   <= '0;
            if (cache_hit) begin
                out_result <= hit_result;
                state      <= DONE;
            end else begin
                state <= BUSY;
            end
        end else begin
            case (state)
                IDLE: state <= IDLE;
                BUSY: begin
                    if (div_complete) begin
                        state <= CAPT;
                    end else if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) begin
                        div_err    <= 1'b1;
                        out_result <= '0;
                        state      <= DONE;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
                end
                CAPT: begin
                    out_result <= mod_sel ? div_r : div_s;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 34-cycle divider and a result scoreboard.
// Build with +define+DIV_RESULT_CACHE_EN to exercise the result cache.
module tb_div_issue_ctrl;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'd0;
    logic [31:0]      in_src1 = 32'd0;
    logic [31:0]      in_src2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             div_go;
    logic             div_signed;
    logic [31:0]      div_x;
    logic [31:0]      div_y;
    logic             div_complete;
    logic [31:0]      div_s = 32'd0;
    logic [31:0]      div_r = 32'd0;
    logic             busy;
    logic             div_err;
    logic             hang = 1'b0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TAG_W(TAG_W), .WDOG_CYC(48)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .div_go(div_go), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_complete(div_complete), .div_s(div_s), .div_r(div_r),
        .busy(busy), .div_err(div_err)
    );

    // Behavioural divider: completes on the 34th consecutive div_go cycle, results appear the cycle after.
    function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (s) return $signed(x) / $signed(y);
        return x / y;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (y == 32'd0) return x;
        if (s) return $signed(x) % $signed(y);
        return x % y;
    endfunction

    logic [5:0] dcnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) dcnt <= 6'd0;
        else if (!div_go) dcnt <= 6'd0;
        else dcnt <= dcnt + 6'd1;
    end
    assign div_complete = div_go && (dcnt == 6'd33) && !hang;
    always @(posedge clk) begin
        if (div_complete) begin
            div_s <= ref_q(div_x, div_y, div_signed);
            div_r <= ref_r(div_x, div_y, div_signed);
        end
    end

    int cyc = 0;
    int go_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (div_go) go_cnt++;
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               gos;
        int               acc;
        int               go0;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    // Bench-side view of the cache contents, used only to predict latency.
    logic        m_valid = 1'b0;
    logic        m_s = 1'b0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input bit push);
        exp_t e;
        bit   hit;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 1);
`ifdef DIV_RESULT_CACHE_EN
        hit = m_valid && (m_a == a) && (m_b == b) && (m_s == !op[1]);
`else
        hit = 1'b0;
`endif
        e.res = res;
        e.tag = tag;
        e.acc = cyc;
        e.go0 = go_cnt;
        e.lat = hit ? 1 : (hang ? 49 : 36);
        e.gos = hit ? 0 : (hang ? 48 : 34);
        if (push) begin
            sb.push_back(e);
            if (!hit && !hang) begin
                m_valid = 1'b1;
                m_a = a;
                m_b = b;
                m_s = !op[1];
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_front(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 1);
        check({name, "_sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({name, "_lat"}, cyc - e.acc, e.lat);
        check({name, "_gocycles"}, go_cnt - e.go0, e.gos);
        check({name, "_result"}, out_result, e.res);
        check({name, "_tag"}, 32'(out_tag), 32'(e.tag));
    endtask

    task automatic recv(input string name);
        check_front(name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drop"}, 32'(out_valid), 0);
    endtask

    task automatic flush_at(input int k, input string name);
        bit seen;
        send(2'd0, 32'd1000 + k, 32'd3, 5'd5, 32'd0, 1'b0);
        repeat (k - 1) @(negedge clk);
        flush = 1'b1;
        check({name, "_inready"}, 32'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        check({name, "_go"}, 32'(div_go), 0);
        check({name, "_valid"}, 32'(out_valid), 0);
        check({name, "_busy"}, 32'(busy), 0);
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({name, "_novalid"}, 32'(seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_go", 32'(div_go), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(div_err), 0);
        check("rst_signed", 32'(div_signed), 0);
        check("rst_x", div_x, 0);
        check("rst_y", div_y, 0);
        check("rst_result", out_result, 0);
        check("rst_tag", 32'(out_tag), 0);
        check("rst_inready", 32'(in_ready), 1);
        resetn = 1'b1;
        @(negedge clk);

        send(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b1);
        check("divw_go", 32'(div_go), 1);
        check("divw_signed", 32'(div_signed), 1);
        check("divw_x", div_x, 32'hFFFF_FFF9);
        check("divw_y", div_y, 32'd2);
        recv("divw");
        send(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b1);
        recv("modw");
        send(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h7FFF_FFFC, 1'b1);
        check("divwu_signed", 32'(div_signed), 0);
        recv("divwu");
        send(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'd1, 1'b1);
        recv("modwu");

        flush_at(10, "flush10");
        flush_at(34, "flush34");
        send(2'd0, 32'd100, 32'd7, 5'd6, 32'd14, 1'b1);
        recv("after_flush");

        send(2'd0, 32'd100, 32'd7, 5'd7, 32'd14, 1'b1);
        check_front("bp");
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_result", out_result, 32'd14);
            check("bp_hold_tag", 32'(out_tag), 7);
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("b2b_go_low", 32'(div_go), 0);
        send(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1, 1'b1);
        out_ready = 1'b0;
        check("b2b_go_high", 32'(div_go), 1);
        check("b2b_valid_low", 32'(out_valid), 0);
        recv("b2b");

        hang = 1'b1;
        send(2'd0, 32'd5, 32'd1, 5'd9, 32'd0, 1'b1);
        check_front("wdog");
        check("wdog_err", 32'(div_err), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        hang = 1'b0;
        send(2'd0, 32'd9, 32'd3, 5'd10, 32'd3, 1'b1);
        recv("post_wdog");
        check("err_sticky", 32'(div_err), 1);

        send(2'd0, 32'd77, 32'd5, 5'd11, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_go", 32'(div_go), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(div_err), 0);
        check("midrst_x", div_x, 0);
        check("midrst_tag", 32'(out_tag), 0);
        m_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        send(2'd0, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1);
        recv("rep_div");
        send(2'd1, 32'd100, 32'd7, 5'd13, 32'd2, 1'b1);
        recv("rep_mod");
        send(2'd2, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1);
        recv("dz_div");
        send(2'd3, 32'd5, 32'd0, 5'd15, 32'd5, 1'b1);
        recv("dz_mod");

        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencing controller between the EX stage and the 34-cycle iterative divider.
- Accepts one div.w / mod.w / div.wu / mod.wu op per valid/ready handshake.
- Holds the divider operands stable and drives the divider's level-sensitive start.
- Captures the quotient or remainder and presents it downstream with valid/ready backpressure.
- Handles pipeline flush mid-operation and a stuck-divider watchdog.

Parameters:
TAG_W, 5, width of the destination tag carried alongside the op
WDOG_CYC, 48, maximum BUSY cycles before declaring the divider hung

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  cancel any in-flight op (exception/ertn), highest priority
in_valid  in  1  upstream op valid
in_ready  out  1  controller can accept an op this cycle
in_op  in  2  0=div.w 1=mod.w 2=div.wu 3=mod.wu
in_src1  in  32  dividend
in_src2  in  32  divisor
in_tag  in  TAG_W  destination tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  32  quotient (div) or remainder (mod)
out_tag  out  TAG_W  tag of the result
div_go  out  1  divider start level (the divider's run input)
div_signed  out  1  signed-operation select to divider
div_x  out  32  dividend to divider, registered
div_y  out  32  divisor to divider, registered
div_complete  in  1  divider one-cycle completion pulse
div_s  in  32  divider quotient
div_r  in  32  divider remainder
busy  out  1  state != IDLE
div_err  out  1  sticky watchdog error

Behaviour:
- Reset values:
  - State IDLE; watchdog counter 0; div_err 0.
  - out_valid, div_go, div_signed: 0.
  - div_x, div_y, out_result, out_tag: 0.
- States: IDLE, BUSY, CAPT, DONE.
- Handshake:
  - in_ready = !flush & (IDLE | (DONE & out_ready)).
  - Accept on in_valid & in_ready.
  - Accept edge latches src1/src2 into div_x/div_y, sets div_signed = !in_op[1], stores in_op[0] (mod select) and the tag, and moves to BUSY.
- Divider start:
  - div_go = (state == BUSY), registered-state decode only.
  - The accept cycle always has div_go=0, which guarantees the divider counter is reinitialised between ops.
- BUSY:
  - div_x, div_y, div_signed are held constant.
  - On div_complete, go to CAPT.
  - Watchdog counter increments each BUSY cycle and clears on entering BUSY.
- Latency: div_complete is expected on the 34th BUSY cycle.
- CAPT (1 cycle, div_go=0):
  - Register out_result = mod ? div_r : div_s. The remainder is only valid the cycle after complete, so both are sampled here.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result/out_tag stable until out_ready.
  - On out_ready: go to IDLE, or go to BUSY if a new op is accepted in the same cycle (back-to-back).
- Accept-to-out_valid latency: 36 cycles.
- Watchdog:
  - If the counter reaches WDOG_CYC in BUSY with no complete: set div_err (sticky until reset), go to DONE with out_result=0.
- Flush, any state:
  - Next state IDLE; out_valid drops next cycle; in_ready=0 during the flush cycle.
  - A div_complete arriving in a flush cycle is ignored.
- Simultaneous out_ready & flush in DONE: flush wins; result is discarded.
- Divide by zero: no trap. The divider's raw output is passed through, and the controller timing is unchanged.
- Reset asserted mid-op: immediate return to reset values, with div_go low asynchronously.

Optional Feature:
Macro DIV_RESULT_CACHE_EN.
- Defined:
  - A one-entry cache holds {src1, src2, signed, quotient, remainder}, filled in CAPT only for a non-watchdog completion.
  - Cleared only by reset; flush does not invalidate it.
  - On a hit (cache valid and src1, src2, signed all equal) at the accept edge, the selected cached value loads into out_result and the state goes straight to DONE, giving out_valid 1 cycle after accept.
  - The divider is not started on a hit.
- Undefined: no cache storage; every op takes the 36-cycle path.

Test Plan:
- div.w src1=0xFFFFFFF9 (-7), src2=2 -> out_result=0xFFFFFFFD (-3), out_valid exactly 36 cycles after accept.
- mod.w -7,2 -> 0xFFFFFFFF; div.wu 0xFFFFFFF9,2 -> 0x7FFFFFFC; mod.wu 0xFFFFFFF9,2 -> 1.
- Flush on BUSY cycle 10 -> no out_valid, div_go low next cycle; following div.w 100,7 -> 14 with correct latency.
- out_ready low 5 cycles in DONE -> out_valid/out_result=14 held stable; out_ready with in_valid same cycle -> back-to-back accept, div_go low for exactly 1 cycle between ops.
- Divider model never pulses div_complete -> div_err=1 after 48 BUSY cycles, out_result=0, div_err stays 1 until resetn low.
- With DIV_RESULT_CACHE_EN: div.w 100,7 then mod.w 100,7 -> 14, then 2 with out_valid 1 cycle after accept and div_go never asserted for the second op.
